// File: rtl/mem_arb_pkg.sv
// Shared constants and request payload for the single-port memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic GNT_INST = 1'b0;
   localparam logic GNT_DATA = 1'b1;

   typedef struct packed {
      logic              wr;
      logic [STRB_W-1:0] wstrb;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/arb_fixed_pri2.sv
// Two-input fixed-priority arbiter; req[1] always beats req[0].
module arb_fixed_pri2 (
   input  logic [1:0] req,
   output logic [1:0] gnt_c
);

   always_comb begin
      gnt_c    = 2'b00;
      gnt_c[1] = req[1];
      gnt_c[0] = req[0] & ~req[1];
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store; one transaction in flight.
module mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,

   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [STRB_W-1:0] data_wstrb,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,

   output logic              mem_req,
   output logic              mem_wr,
   output logic [STRB_W-1:0] mem_wstrb,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic [1:0] state_q, state_d;
   mem_req_t   req_q, req_d;
   logic       gnt_id_q, gnt_id_d;
   logic [1:0] gnt_c;

   arb_fixed_pri2 u_arb (
      .req   ({data_req, inst_req}),
      .gnt_c (gnt_c)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         req_q    <= '0;
         gnt_id_q <= GNT_INST;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         gnt_id_q <= gnt_id_d;
      end
   end

   // Handshakes are combinational so a grant or response costs no extra cycle.
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      gnt_id_d     = gnt_id_q;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_c != 2'b00) begin
               inst_addr_ok = gnt_c[0] & resetn;
               data_addr_ok = gnt_c[1] & resetn;
               state_d      = ST_ISSUE;
               if (gnt_c[1]) begin
                  gnt_id_d    = GNT_DATA;
                  req_d.wr    = data_wr;
                  req_d.wstrb = data_wstrb;
                  req_d.addr  = data_addr;
                  req_d.wdata = data_wdata;
               end else begin
                  gnt_id_d    = GNT_INST;
                  req_d.wr    = 1'b0;
                  req_d.wstrb = '0;
                  req_d.addr  = inst_addr;
                  req_d.wdata = '0;
               end
            end
         end
         ST_ISSUE: begin
            if (mem_addr_ok) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_data_ok) begin
               inst_data_ok = (gnt_id_q == GNT_INST);
               data_data_ok = (gnt_id_q == GNT_DATA);
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_req    = (state_q == ST_ISSUE);
   assign mem_wr     = req_q.wr;
   assign mem_wstrb  = req_q.wstrb;
   assign mem_addr   = req_q.addr;
   assign mem_wdata  = req_q.wdata;
   assign inst_rdata = mem_rdata;
   assign data_rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  Single clock; all state updates on the rising edge.
REQ-002 resetn  in  1  Reset, asynchronous, active-low.
REQ-003 inst_req  in  1  Fetch-side read request.
REQ-004 inst_addr  in  32  Fetch address.
REQ-005 inst_addr_ok  out  1  Fetch request accepted this cycle.
REQ-006 inst_data_ok  out  1  Fetch read data valid this cycle.
REQ-007 inst_rdata  out  32  Fetch read data.
REQ-008 data_req  in  1  Load/store request.
REQ-009 data_wr  in  1  1 means store, 0 means load.
REQ-010 data_wstrb  in  4  Store byte strobes.
REQ-011 data_addr  in  32  Load/store address.
REQ-012 data_wdata  in  32  Store data.
REQ-013 data_addr_ok  out  1  Load/store request accepted this cycle.
REQ-014 data_data_ok  out  1  Load data valid, or store complete, this cycle.
REQ-015 data_rdata  out  32  Load data.
REQ-016 mem_req  out  1  Shared memory port request.
REQ-017 mem_wr  out  1  Shared port write flag.
REQ-018 mem_wstrb  out  4  Shared port byte strobes.
REQ-019 mem_addr  out  32  Shared port address.
REQ-020 mem_wdata  out  32  Shared port write data.
REQ-021 mem_addr_ok  in  1  Memory accepted the request.
REQ-022 mem_data_ok  in  1  Memory response valid.
REQ-023 mem_rdata  in  32  Memory read data.

Function
REQ-024 The controller SHALL be a three-state machine: IDLE, ISSUE and WAIT. Only one transaction is outstanding at any time.
REQ-025 In IDLE with any request pending, the controller SHALL grant one requester and assert that requester's addr_ok combinationally in the same cycle.
- On the next edge it latches the request fields (addr, wr, wstrb, wdata) and a grant-id flag, then moves to ISSUE.
REQ-026 When inst_req and data_req are both high in IDLE, data SHALL win; inst_addr_ok stays 0 and the fetch request is held by the fetch stage.
REQ-027 For a fetch grant, the latched request SHALL be wr=0, wstrb=0, wdata=0.
REQ-028 In ISSUE, mem_req SHALL be 1 and the mem_* fields SHALL come from the latched registers.
- On mem_addr_ok=1 the controller moves to WAIT.
- Otherwise it holds ISSUE with the fields stable.
REQ-029 In WAIT, mem_req SHALL be 0. On mem_data_ok=1:
- The granted requester's data_ok is asserted combinationally for exactly that cycle.
- Its rdata is driven from mem_rdata.
- The controller returns to IDLE.
REQ-030 Any addr_ok SHALL assert only in IDLE. This leaves at least one bubble cycle between a data_ok and the next grant.
REQ-031 mem_data_ok SHALL be ignored in IDLE and ISSUE; mem_addr_ok SHALL be ignored in IDLE and WAIT.
REQ-032 The non-granted requester's data_ok SHALL stay 0. Both rdata outputs SHALL equal mem_rdata at all times; they are qualified only by data_ok.
REQ-033 For a store, data_data_ok SHALL still pulse once in WAIT; data_rdata is then don't-care.
REQ-034 Minimum latency, with mem_addr_ok and mem_data_ok each returned on the first eligible cycle:
- addr_ok in cycle N.
- mem_req in cycle N+1.
- data_ok in cycle N+2.

Reset
REQ-035 resetn=0 SHALL asynchronously force:
- state = IDLE;
- all latched request registers and the grant-id to 0;
- all addr_ok, data_ok, mem_req, mem_wr and mem_wstrb outputs to 0.
REQ-036 A reset during ISSUE or WAIT SHALL abandon the in-flight transaction. A mem_data_ok arriving after reset release SHALL NOT reach either requester.

Structure
REQ-037 The state encoding and the grant-id constants (GNT_INST=0, GNT_DATA=1) SHALL live in a shared package, mem_arb_pkg.
REQ-038 The fixed-priority grant logic SHALL be a sub-module, arb_fixed_pri2, with two requests in and a one-hot grant out. Everything else is flat.

Verification
REQ-039 Lone fetch: inst_req=1 with inst_addr=0x1c000000 in IDLE, memory returns 0x02bffc0c.
- Response: inst_addr_ok in N; mem_addr=0x1c000000 and mem_wr=0 in N+1; inst_data_ok with rdata 0x02bffc0c in N+2.
REQ-040 Simultaneous requests: inst and data request in the same cycle, data is a load from 0x80.
- Response: data_addr_ok=1 and inst_addr_ok=0.
- The fetch is granted in the IDLE cycle after data_data_ok.
REQ-041 Store with stalled memory: store to addr 0x100, wdata 0xdeadbeef, wstrb 0x3; mem_addr_ok is held 0 for 3 cycles.
- Response: mem_req=1 with all fields stable for 4 cycles.
- data_data_ok pulses once; inst_data_ok stays 0.
REQ-042 Stray response: mem_data_ok=1 while in IDLE or ISSUE.
- Response: no data_ok pulse and no state change.
REQ-043 Reset in WAIT: assert resetn=0 mid-cycle during WAIT, then release it, then memory returns mem_data_ok=1.
- Response: all outputs are 0 immediately on reset.
- After release the state is IDLE and no data_ok is produced.
